// File: rtl/core1_sequencer.sv
// core1_sequencer
//
// Request/response front end for the combinational GF(2^m) operation core
// (square, XOR, mask, LUT multiply). One operation is in flight at a time.
// An accepted request loads registered operands and a select into the core.
// The inputs are held for SETTLE cycles, and then the core's two result
// halves are captured and offered on the response channel. Core inputs
// are always driven, never Z. They read 0 whenever no operation is being
// driven.
//
// Ports:
//   clk        in   1    rising-edge clock
//   rst        in   1    asynchronous active-high reset
//   req_valid  in   1    request valid
//   req_ready  out  1    high in IDLE; accept = req_valid && req_ready
//   req_op     in   3    opcode (1 SQR, 2 XOR, 3 LUT, 4 MASK; others illegal)
//   req_a      in   256  operand A
//   req_b      in   256  operand B
//   core_a     out  256  registered operand A to core
//   core_b     out  256  registered operand B to core
//   core_sel   out  3    registered select to core, 0 when not driving
//   core_c     in   128  core upper result
//   core_d     in   128  core lower result
//   rsp_valid  out  1    response valid
//   rsp_ready  in   1    response consumed when high with rsp_valid
//   rsp_c      out  128  captured upper result
//   rsp_d      out  128  captured lower result
//   rsp_op     out  3    opcode of this response
//   rsp_err    out  1    illegal opcode flag
//   busy       out  1    high in every state except IDLE
module core1_sequencer #(
    parameter int SETTLE = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [2:0]   req_op,
    input  logic [255:0] req_a,
    input  logic [255:0] req_b,
    output logic [255:0] core_a,
    output logic [255:0] core_b,
    output logic [2:0]   core_sel,
    input  logic [127:0] core_c,
    input  logic [127:0] core_d,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_c,
    output logic [127:0] rsp_d,
    output logic [2:0]   rsp_op,
    output logic         rsp_err,
    output logic         busy
);

    localparam logic [2:0] OP_SQR  = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_LUT  = 3'b011;
    localparam logic [2:0] OP_MASK = 3'b100;

    // The counter counts down to zero. The capture happens on the edge
    // where it already reads zero, so it is loaded with SETTLE-1. That
    // holds the core inputs for exactly SETTLE cycles.
    localparam logic [7:0] CNT_LOAD = 8'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t         state;
    logic [7:0]     cnt;
    logic           op_legal;
    logic [255:0]   op_a;
    logic [255:0]   op_b;

    assign req_ready = (state == IDLE);

    // Shape the operands for the selected operation. Bits the core does
    // not use are forced to zero so stale upper operand bits never reach it.
    always_comb begin
        op_legal = 1'b0;
        op_a     = '0;
        op_b     = '0;
        case (req_op)
            OP_SQR: begin
                op_legal = 1'b1;
                op_a     = {128'b0, req_a[127:0]};
            end
            OP_XOR: begin
                op_legal = 1'b1;
                op_a     = req_a;
                op_b     = req_b;
            end
            OP_LUT: begin
                op_legal = 1'b1;
                op_a     = {192'b0, req_a[63:0]};
                op_b     = {192'b0, req_b[63:0]};
            end
            OP_MASK: begin
                op_legal = 1'b1;
                op_a     = {192'b0, req_a[63:0]};
                op_b     = {248'b0, req_b[7:0]};
            end
            default: begin
                op_legal = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            core_a    <= '0;
            core_b    <= '0;
            core_sel  <= 3'd0;
            rsp_valid <= 1'b0;
            rsp_c     <= '0;
            rsp_d     <= '0;
            rsp_op    <= 3'd0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        busy <= 1'b1;
                        if (op_legal) begin
                            core_sel <= req_op;
                            core_a   <= op_a;
                            core_b   <= op_b;
                            cnt      <= CNT_LOAD;
                            state    <= DRIVE;
                        end else begin
                            // Illegal opcodes never touch the core. They
                            // answer immediately with an error response.
                            rsp_c     <= '0;
                            rsp_d     <= '0;
                            rsp_op    <= req_op;
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end

                DRIVE: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        rsp_c     <= core_c;
                        rsp_d     <= core_d;
                        rsp_op    <= core_sel;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        core_a    <= '0;
                        core_b    <= '0;
                        core_sel  <= 3'd0;
                        state     <= RESP;
                    end
                end

                RESP: begin
                    // The response payload stays in place after the handshake.
                    // Only the valid and busy flags drop.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/core1_sequencer.md
# core1_sequencer

Request/response front end for the combinational GF(2^m) operation core (XOR, squaring, masking, LUT multiply). It accepts one operation at a time over a valid/ready request channel and drives the core's operand and select inputs from registers. After a programmable settle time it captures the core's two 128-bit result halves and returns them over a valid/ready response channel. It sits between the ECC point-arithmetic state machine and the core, so no core input is ever driven to Z.

## Interface
- SQR, 3'b001, opcode: square A[127:0]
- XOR, 3'b010, opcode: 256-bit XOR
- LUT, 3'b011, opcode: LUT multiply, A[63:0] by B[63:0]
- MASK, 3'b100, opcode: mask A[63:0] with B[7:0]
- SETTLE, 2, cycles core inputs are held before sampling; legal range 1..255
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when high with req_valid
- req_op  in  3  opcode
- req_a  in  256  operand A
- req_b  in  256  operand B
- core_a  out  256  registered operand A to core
- core_b  out  256  registered operand B to core
- core_sel  out  3  registered select to core; 0 when idle
- core_c  in  128  core upper result
- core_d  in  128  core lower result
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_c  out  128  captured upper result
- rsp_d  out  128  captured lower result
- rsp_op  out  3  opcode of this response
- rsp_err  out  1  illegal opcode flag
- busy  out  1  high in every state except IDLE

## Operation
- The block is a state machine with three states: IDLE, DRIVE and RESP. It has one outstanding operation and no queue.
- **IDLE:**
  - req_ready=1.
  - core_a, core_b and core_sel are all 0.
  - req_* is sampled only on the accept edge (req_valid&&req_ready). Changes at any other time are ignored.
- **Accept with a legal opcode (1..4):**
  - Load core_sel=req_op.
  - Load operands with unused bits forced to 0:
    - SQR: core_a={128'b0,req_a[127:0]}, core_b=0.
    - XOR: core_a=req_a, core_b=req_b.
    - LUT: core_a={192'b0,req_a[63:0]}, core_b={192'b0,req_b[63:0]}.
    - MASK: core_a={192'b0,req_a[63:0]}, core_b={248'b0,req_b[7:0]}.
  - Load the 8-bit counter cnt=SETTLE-1 and go to DRIVE.
- **Accept with an illegal opcode (0,5,6,7):**
  - The core is not driven.
  - Load rsp_c=0, rsp_d=0, rsp_op=req_op, rsp_err=1 and go directly to RESP.
- **DRIVE:**
  - The core inputs are held stable.
  - If cnt!=0, decrement cnt.
  - If cnt==0, capture rsp_c=core_c, rsp_d=core_d, rsp_op=core_sel and rsp_err=0. On the same edge, clear core_a, core_b and core_sel to 0 and go to RESP.
- **RESP:**
  - rsp_valid=1, and rsp_* is held stable until the handshake.
  - On rsp_valid&&rsp_ready, go to IDLE. rsp_valid falls; rsp_c, rsp_d, rsp_op and rsp_err keep their last values.
- **Reset:**
  - Asynchronous, effective immediately, including mid-operation.
  - State goes to IDLE and every output register is cleared to 0.
  - Any in-flight operation is dropped and no response is emitted after release.
  - After rst deasserts: req_ready=1, busy=0, rsp_valid=0.

## Timing
- Reset values:
  - req_ready=1 (combinational from IDLE; reads 1 while rst is high).
  - All other outputs 0: rsp_valid, rsp_c, rsp_d, rsp_op, rsp_err, core_a, core_b, core_sel, busy.
- Accept edge E0 → core inputs valid from the cycle after E0, for exactly SETTLE cycles.
- The capture edge is E0+SETTLE; rsp_valid is high from the cycle after it.
- Illegal opcode: rsp_valid is high from the cycle after E0 (latency 1).
- req_ready is low from E0 until the cycle after the response handshake. With rsp_ready tied high, the minimum accept-to-accept spacing is SETTLE+2 cycles.
- rsp_ready is ignored outside RESP. req_valid is ignored outside IDLE.
- The core is combinational. The SETTLE cycles of stable inputs are the only timing guarantee given to it.

## Test plan
- **XOR, SETTLE=2.**
  - Stimulus: req_a={128'h1,128'hF0}, req_b={128'h3,128'h0F}, behavioural core model.
  - Required: rsp_c=128'h2, rsp_d=128'hFF, rsp_op=2, rsp_err=0.
  - Required: core_sel=2 for exactly 2 cycles, then 0; rsp_valid high 2 cycles after accept.
- **MASK.**
  - Stimulus: req_b=256'hFFFF_A5 (upper bits set), req_a all ones.
  - Required: core_b=256'hA5 and core_a=64'hFFFF_FFFF_FFFF_FFFF zero-extended during DRIVE.
- **Illegal opcode.**
  - Stimulus: req_op=3'b111.
  - Required: rsp_valid high 1 cycle after accept; rsp_err=1; rsp_c=rsp_d=0; core_sel stays 0 throughout.
- **Backpressure.**
  - Stimulus: rsp_ready low for 5 cycles in RESP while req_valid is held high with a new request.
  - Required: rsp_* stable, req_ready=0 and no second accept. The second accept occurs 1 cycle after the rsp handshake.
- **Reset mid-operation.**
  - Stimulus: assert rst during DRIVE.
  - Required: core_sel, core_a, core_b and busy go to 0 without a clock edge; req_ready reads 1. No rsp_valid for 10 cycles after release; a new request then completes normally.
- **Back-to-back.**
  - Stimulus: two SQR requests queued by the bench, rsp_ready tied high, SETTLE=3.
  - Required: accepts at cycles 0 and 5; each response equals the bit-interleaved square of its own A.
